// File: rtl/matrix_op_conv_param.sv
// KxK 2-D convolution engine (stride 1/2, same/valid padding) on the shared single-port BRAM.
// Optional build macro CONV_SATURATE_EN clamps results to all-ones instead of wrapping.
module matrix_op_conv_param #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int DIM_WIDTH     = 5,
    parameter int MAX_DIM       = 16,
    parameter int KMAX          = 5,
    parameter int ACC_WIDTH     = 2 * ELEMENT_WIDTH + 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    input  logic [DIM_WIDTH-1:0]     dim_m,
    input  logic [DIM_WIDTH-1:0]     dim_n,
    input  logic [3:0]               k_size,
    input  logic [1:0]               stride,
    input  logic                     pad_mode,
    input  logic [ADDR_WIDTH-1:0]    addr_op1,
    input  logic [ADDR_WIDTH-1:0]    addr_op2,
    input  logic [ADDR_WIDTH-1:0]    addr_res,
    output logic [DIM_WIDTH-1:0]     out_m,
    output logic [DIM_WIDTH-1:0]     out_n,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);
    localparam int KK = KMAX * KMAX;
    localparam int KW = $clog2(KK + 1);
    localparam int CW = DIM_WIDTH + 3;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LOAD_K, S_PIX_INIT, S_TAP, S_RD,
        S_RD_WAIT, S_MAC, S_WRITE, S_NEXT_PIX, S_DONE, S_ERR
    } state_t;

    state_t state, state_nx;

    logic [DIM_WIDTH-1:0]     dm, dn, oi, oj, calc_m, calc_n;
    logic [3:0]               ks, ki, kj, half, ki_step, kj_step;
    logic [1:0]               st;
    logic                     pm;
    logic [ADDR_WIDTH-1:0]    a_img, a_ker, a_res, tap_addr, res_addr;
    logic [KW-1:0]            ld_cnt, kk, kidx;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ELEMENT_WIDTH-1:0] img;
    logic [ELEMENT_WIDTH-1:0] kcache [KK];
    logic signed [CW-1:0]     tap_r, tap_c;
    logic                     in_bounds, tap_last, pix_last, cfg_bad;

    function automatic logic [ELEMENT_WIDTH-1:0] sat_elem(input logic [ACC_WIDTH-1:0] a);
`ifdef CONV_SATURATE_EN
        if (a > ACC_WIDTH'({ELEMENT_WIDTH{1'b1}}))
            return '1;
        return ELEMENT_WIDTH'(a);
`else
        return ELEMENT_WIDTH'(a);
`endif
    endfunction

    // same: ceil(d/s) = (d+s-1)/s; valid: (d-k)/s+1 = (d-k+s)/s; s is 1 or 2
    function automatic logic [DIM_WIDTH-1:0] out_dim(input logic [DIM_WIDTH-1:0] d,
                                                     input logic [3:0] k, input logic [1:0] s,
                                                     input logic valid_pad);
        logic [DIM_WIDTH-1:0] span;
        span = valid_pad ? d - DIM_WIDTH'(k) + DIM_WIDTH'(s) : d + DIM_WIDTH'(s) - DIM_WIDTH'(1);
        return (s == 2'd2) ? span >> 1 : span;
    endfunction

    assign calc_m = out_dim(dm, ks, st, pm);
    assign calc_n = out_dim(dn, ks, st, pm);

    assign cfg_bad = (dm == '0) || (dm > DIM_WIDTH'(MAX_DIM)) || (dn == '0) ||
                     (dn > DIM_WIDTH'(MAX_DIM)) || !ks[0] || (ks > 4'(KMAX)) ||
                     ((st != 2'd1) && (st != 2'd2)) ||
                     (pm && ((DIM_WIDTH'(ks) > dm) || (DIM_WIDTH'(ks) > dn)));

    assign half  = pm ? 4'd0 : (ks - 4'd1) >> 1;
    assign tap_r = $signed(CW'(oi) * CW'(st) + CW'(ki)) - $signed(CW'(half));
    assign tap_c = $signed(CW'(oj) * CW'(st) + CW'(kj)) - $signed(CW'(half));
    assign in_bounds = !tap_r[CW-1] && !tap_c[CW-1] &&
                       (tap_r < $signed(CW'(dm))) && (tap_c < $signed(CW'(dn)));

    assign tap_addr = a_img + ADDR_WIDTH'($unsigned(tap_r)) * ADDR_WIDTH'(dn) +
                      ADDR_WIDTH'($unsigned(tap_c));
    assign res_addr = a_res + ADDR_WIDTH'(oi) * ADDR_WIDTH'(out_n) + ADDR_WIDTH'(oj);

    assign kk       = KW'(ks) * KW'(ks);
    assign kidx     = KW'(ki) * KW'(ks) + KW'(kj);
    assign tap_last = (ki == ks - 4'd1) && (kj == ks - 4'd1);
    assign kj_step  = (kj == ks - 4'd1) ? 4'd0 : kj + 4'd1;
    assign ki_step  = (kj == ks - 4'd1) ? ki + 4'd1 : ki;
    assign pix_last = (oi == out_m - DIM_WIDTH'(1)) && (oj == out_n - DIM_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            out_m  <= '0;
            out_n  <= '0;
            ld_cnt <= '0;
            ki     <= '0;
            kj     <= '0;
            oi     <= '0;
            oj     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_CFG: begin
                    out_m  <= calc_m;
                    out_n  <= calc_n;
                    ld_cnt <= '0;
                    oi     <= '0;
                    oj     <= '0;
                end
                S_LOAD_K:   ld_cnt <= ld_cnt + KW'(1);
                S_PIX_INIT: begin
                    ki <= '0;
                    kj <= '0;
                end
                S_TAP: if (!in_bounds && !tap_last) begin
                    ki <= ki_step;
                    kj <= kj_step;
                end
                S_MAC: if (!tap_last) begin
                    ki <= ki_step;
                    kj <= kj_step;
                end
                S_NEXT_PIX: begin
                    if (oj == out_n - DIM_WIDTH'(1)) begin
                        oj <= '0;
                        oi <= oi + DIM_WIDTH'(1);
                    end else begin
                        oj <= oj + DIM_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands and datapath: only ever consumed after being loaded for the current op
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            dm    <= dim_m;
            dn    <= dim_n;
            ks    <= k_size;
            st    <= stride;
            pm    <= pad_mode;
            a_img <= addr_op1;
            a_ker <= addr_op2;
            a_res <= addr_res;
        end
        if (state == S_LOAD_K && ld_cnt != '0)
            kcache[ld_cnt - KW'(1)] <= mem_rd_data;
        if (state == S_RD_WAIT)
            img <= mem_rd_data;
        if (state == S_PIX_INIT)
            acc <= '0;
        else if (state == S_MAC)
            acc <= acc + ACC_WIDTH'(img) * ACC_WIDTH'(kcache[kidx]);
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        err_cfg     = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            S_IDLE: if (start) state_nx = S_CFG;
            S_CFG: begin
                busy     = 1'b1;
                state_nx = cfg_bad ? S_ERR : S_LOAD_K;
            end
            S_LOAD_K: begin
                busy = 1'b1;
                if (ld_cnt < kk) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = a_ker + ADDR_WIDTH'(ld_cnt);
                end else begin
                    state_nx = S_PIX_INIT;
                end
            end
            S_PIX_INIT: begin
                busy     = 1'b1;
                state_nx = S_TAP;
            end
            S_TAP: begin
                busy = 1'b1;
                if (in_bounds)
                    state_nx = S_RD;
                else if (tap_last)
                    state_nx = S_WRITE;
            end
            S_RD: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = tap_addr;
                state_nx    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy     = 1'b1;
                state_nx = S_MAC;
            end
            S_MAC: begin
                busy     = 1'b1;
                state_nx = tap_last ? S_WRITE : S_TAP;
            end
            S_WRITE: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_addr = res_addr;
                mem_wr_data = sat_elem(acc);
                state_nx    = S_NEXT_PIX;
            end
            S_NEXT_PIX: begin
                busy     = 1'b1;
                state_nx = pix_last ? S_DONE : S_PIX_INIT;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_nx = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err_cfg = 1'b1;
                if (!start) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_matrix_op_conv_param.sv
// Directed bench for matrix_op_conv_param: BRAM model, write scoreboard, immediate assertions.
`timescale 1ns/1ps
module tb_matrix_op_conv_param;
    localparam int EW = 8;
    localparam int AW = 10;
    localparam int DW = 5;
    localparam int IMG = 0;
    localparam int KER = 100;
    localparam int RES = 200;
    localparam int BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err_cfg;
    logic [DW-1:0] dim_m = '0, dim_n = '0;
    logic [3:0]    k_size = '0;
    logic [1:0]    stride = '0;
    logic          pad_mode = 1'b0;
    logic [AW-1:0] addr_op1 = '0, addr_op2 = '0, addr_res = '0;
    logic [DW-1:0] out_m, out_n;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [EW-1:0] mem_rd_data;
    logic [EW-1:0] mem_wr_data;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int n_asrt = 0;
    int n_fail = 0;
    int overlap_cnt = 0;
    int exp_om, exp_on;
    logic [EW-1:0] mem [0:(1<<AW)-1];

    matrix_op_conv_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err_cfg(err_cfg),
        .dim_m(dim_m), .dim_n(dim_n), .k_size(k_size), .stride(stride), .pad_mode(pad_mode),
        .addr_op1(addr_op1), .addr_op2(addr_op2), .addr_res(addr_res),
        .out_m(out_m), .out_n(out_n),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    always @(negedge clk) begin
        if (mem_rd_en && mem_wr_en) overlap_cnt++;
        if (mem_wr_en) obs_q.push_back('{32'(mem_wr_addr), 32'(mem_wr_data)});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fold(input int acc);
`ifdef CONV_SATURATE_EN
        return (acc > 255) ? 32'd255 : 32'(acc);
`else
        return 32'(acc % 256);
`endif
    endfunction

    task automatic push_exp(input int a, input int d);
        exp_q.push_back('{32'(a), 32'(d)});
    endtask

    // Reference convolution over the bench memory image
    task automatic model(input int m, input int n, input int k, input int s, input int pm);
        int h, acc, r, c;
        if (pm == 0) begin
            exp_om = (m + s - 1) / s;
            exp_on = (n + s - 1) / s;
            h = (k - 1) / 2;
        end else begin
            exp_om = (m - k) / s + 1;
            exp_on = (n - k) / s + 1;
            h = 0;
        end
        for (int oi = 0; oi < exp_om; oi++)
            for (int oj = 0; oj < exp_on; oj++) begin
                acc = 0;
                for (int ki = 0; ki < k; ki++)
                    for (int kj = 0; kj < k; kj++) begin
                        r = oi * s + ki - h;
                        c = oj * s + kj - h;
                        if (r >= 0 && r < m && c >= 0 && c < n)
                            acc += int'(mem[IMG + r * n + c]) * int'(mem[KER + ki * k + kj]);
                    end
                exp_q.push_back('{32'(RES + oi * exp_on + oj), fold(acc)});
            end
    endtask

    task automatic drive_cfg(input int m, input int n, input int k, input int s, input int pm);
        dim_m    = DW'(m);
        dim_n    = DW'(n);
        k_size   = 4'(k);
        stride   = 2'(s);
        pad_mode = 1'(pm);
        addr_op1 = AW'(IMG);
        addr_op2 = AW'(KER);
        addr_res = AW'(RES);
    endtask

    task automatic run_op(input string tag, input int m, input int n, input int k,
                          input int s, input int pm, input bit exp_err);
        int cyc;
        wr_t e, o;
        drive_cfg(m, n, k, s, pm);
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, " busy_after_start"}, 32'(busy), 1);
        // scramble the operands; the engine must keep using the latched ones
        dim_m = '0; dim_n = '0; k_size = 4'd2; stride = 2'd3; addr_res = '0; addr_op1 = '1;
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " done_in_budget"}, 32'(cyc < BUDGET), 1);
        chk({tag, " err_cfg"}, 32'(err_cfg), 32'(exp_err));
        chk({tag, " busy_at_done"}, 32'(busy), 0);
        if (!exp_err) begin
            chk({tag, " out_m"}, 32'(out_m), 32'(exp_om));
            chk({tag, " out_n"}, 32'(out_n), 32'(exp_on));
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " done_held"}, 32'(done), 1);
        chk({tag, " n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, " wr_addr"}, o.a, e.a);
            chk({tag, " wr_data"}, o.d, e.d);
        end
        exp_q.delete();
        obs_q.delete();
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle_done"}, 32'(done), 0);
        chk({tag, " idle_err"}, 32'(err_cfg), 0);
    endtask

    task automatic push_same_ones_4x4();
        int tbl[16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
        for (int i = 0; i < 16; i++) push_exp(RES + i, tbl[i]);
        exp_om = 4;
        exp_on = 4;
    endtask

    task automatic load_ones(input int m, input int n, input int k);
        for (int i = 0; i < m * n; i++) mem[IMG + i] = 8'd1;
        for (int i = 0; i < k * k; i++) mem[KER + i] = 8'd1;
    endtask

    initial begin
        int sub[9] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
        int cyc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err_cfg", 32'(err_cfg), 0);
        chk("rst out_m", 32'(out_m), 0);
        chk("rst out_n", 32'(out_n), 0);
        chk("rst rd_en", 32'(mem_rd_en), 0);
        chk("rst wr_en", 32'(mem_wr_en), 0);
        chk("rst wr_data", 32'(mem_wr_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        load_ones(4, 4, 3);
        push_same_ones_4x4();
        run_op("same_ones", 4, 4, 3, 1, 0, 1'b0);

        for (int i = 0; i < 4; i++) push_exp(RES + i, 9);
        exp_om = 2;
        exp_on = 2;
        run_op("valid_ones", 4, 4, 3, 1, 1, 1'b0);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mem[IMG + r * 5 + c] = 8'(r * 5 + c);
        mem[KER] = 8'd1;
        for (int i = 0; i < 9; i++) push_exp(RES + i, sub[i]);
        exp_om = 3;
        exp_on = 3;
        run_op("stride2_same", 5, 5, 1, 2, 0, 1'b0);

        for (int i = 0; i < 9; i++) mem[IMG + i] = 8'd200;
        mem[KER] = 8'd2;
        for (int i = 0; i < 9; i++) push_exp(RES + i, fold(400));
        exp_om = 3;
        exp_on = 3;
        run_op("overflow", 3, 3, 1, 1, 0, 1'b0);

        run_op("err_even_k", 4, 4, 2, 1, 0, 1'b1);
        run_op("err_valid_k5", 4, 4, 5, 1, 1, 1'b1);
        run_op("err_dim0", 0, 4, 3, 1, 0, 1'b1);

        for (int i = 0; i < 30; i++) mem[IMG + i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) mem[KER + i] = 8'($urandom_range(0, 255));
        model(6, 5, 3, 2, 0);
        run_op("rand_same_s2", 6, 5, 3, 2, 0, 1'b0);

        for (int i = 0; i < 42; i++) mem[IMG + i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 25; i++) mem[KER + i] = 8'($urandom_range(0, 255));
        model(7, 6, 5, 1, 1);
        run_op("rand_valid_k5", 7, 6, 5, 1, 1, 1'b0);

        // abort in the middle of the third output write, then rerun from scratch
        load_ones(4, 4, 3);
        drive_cfg(4, 4, 3, 1, 0);
        start = 1'b1;
        cyc = 0;
        while (!(mem_wr_en === 1'b1 && obs_q.size() == 2) && cyc < BUDGET) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("abort reached_third_write", 32'(cyc < BUDGET), 1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort wr_en", 32'(mem_wr_en), 0);
        chk("abort rd_en", 32'(mem_rd_en), 0);
        chk("abort wr_addr", 32'(mem_wr_addr), 0);
        chk("abort out_m", 32'(out_m), 0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort writes_before_reset", 32'(obs_q.size()), 2);
        obs_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_same_ones_4x4();
        run_op("same_ones_after_abort", 4, 4, 3, 1, 0, 1'b0);

        chk("rd_wr_overlap", 32'(overlap_cnt), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
